sti_deserializer: RTL
=====================

STI_DESERIALIZER -- requirements
Module: sti_deserializer

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cfg_load  input  1  one-cycle strobe capturing the cfg_* fields.
REQ-005 cfg_length  input  2  frame length: 0=8, 1=16, 2=24, 3=32 bits.
REQ-006 cfg_msb  input  1  1: first serial bit is frame bit N-1 (descending); 0: first bit is bit 0 (ascending).
REQ-007 cfg_low  input  1  8-bit frames only: 1: byte goes to po_data[15:8]; 0: byte goes to po_data[7:0].
REQ-008 cfg_fill  input  1  24/32-bit frames only: 1: payload occupies the upper 16 frame bits; 0: payload occupies frame bits [15:0].
REQ-009 si_data  input  1  serial data bit, sampled only when si_valid=1.
REQ-010 si_valid  input  1  serial bit qualifier; one bit per cycle while high.
REQ-011 po_data  output  16  reassembled parallel word.
REQ-012 po_valid  output  1  one-cycle strobe, po_data valid.
REQ-013 po_pad_err  output  1  qualified by po_valid: a padding bit in the frame was 1.
REQ-014 frame_err  output  1  one-cycle strobe: frame aborted.
REQ-015 frame_cnt  output  8  count of completed frames, wraps from 255 to 0.
REQ-016 busy  output  1  high while in RECV.

Function
REQ-017 Config registers SHALL load on cfg_load and hold until the next cfg_load; cfg_load and si_valid SHALL NOT be asserted in the same cycle, and si_valid in that cycle SHALL be ignored.
REQ-018 FSM states: IDLE, RECV, OUT.
REQ-019 IDLE: si_valid=1 -> clear the 32-bit assembly register, store the bit, bit count=1, go to RECV.
REQ-020 RECV: si_valid=1 -> store the bit, increment the count; when the stored bit is bit N (N=8/16/24/32) -> go to OUT.
REQ-021 RECV: si_valid=0 -> frame_err=1 for one cycle, discard the partial frame, go to IDLE; po_valid stays 0 and frame_cnt is unchanged.
REQ-022 RECV: cfg_load=1 -> abort the frame as in REQ-021, and load the new config.
REQ-023 Bit placement: with cfg_msb=1, the k-th received bit (k=0..N-1) goes to assembly bit N-1-k; with cfg_msb=0 it goes to bit k.
REQ-024 OUT: po_valid=1 for exactly one cycle; po_data and po_pad_err are valid in that cycle; frame_cnt increments by 1 in that cycle.
REQ-025 Latency: po_valid asserts on the cycle immediately after the cycle in which the last bit is sampled.
REQ-026 OUT with si_valid=1: the bit is the first bit of the next frame (back-to-back frames), go to RECV with count=1; otherwise go to IDLE.
REQ-027 Extraction, 8-bit: low=1 -> {asm[7:0],8'h00}; low=0 -> {8'h00,asm[7:0]}.
REQ-028 Extraction, 16-bit: asm[15:0].
REQ-029 Extraction, 24-bit: fill=1 -> asm[23:8]; fill=0 -> asm[15:0].
REQ-030 Extraction, 32-bit: fill=1 -> asm[31:16]; fill=0 -> asm[15:0].
REQ-031 po_pad_err = OR of the frame bits not used by extraction (24/fill=1: [7:0]; 24/fill=0: [23:16]; 32/fill=1: [15:0]; 32/fill=0: [31:16]); it is 0 for 8- and 16-bit frames.
REQ-032 po_data SHALL hold its last value outside OUT; po_pad_err SHALL be 0 whenever po_valid=0.

Reset
REQ-033 reset=1 at any clock edge, including mid-frame: state=IDLE, assembly register=0, bit count=0, po_data=16'h0000, po_valid=0, po_pad_err=0, frame_err=0, frame_cnt=8'h00, busy=0.
REQ-034 Config after reset: cfg_length=0, cfg_msb=0, cfg_low=0, cfg_fill=0; a partial frame is dropped with no frame_err.

Verification
REQ-035 Test: cfg len=1, msb=1, stream 16'hA5C3 MSB-first -> po_data=16'hA5C3 with po_valid one cycle after bit 16, frame_cnt=1.
REQ-036 Test: cfg len=0, msb=0, low=1, byte 8'h3C LSB-first -> po_data=16'h3C00; then low=0 -> po_data=16'h003C.
REQ-037 Test: cfg len=2, msb=1, fill=1, frame 24'h123400 -> po_data=16'h1234, pad_err=0; frame 24'h123401 -> pad_err=1.
REQ-038 Test: cfg len=3, si_valid dropped after 5 bits -> frame_err pulse, no po_valid, frame_cnt unchanged; then a full frame is received correctly.
REQ-039 Test: two back-to-back 8-bit frames 8'h81, 8'h7E with no gap -> two po_valid pulses 8 cycles apart with the correct data.
REQ-040 Test: reset mid-frame, then 256 good frames -> all outputs at reset values, frame_cnt wraps to 8'h00.

Source files
------------

// File: rtl/sti_deserializer.sv
// Serial-to-parallel frame deserializer: collects 8/16/24/32-bit serial frames
// in either bit order and extracts a 16-bit payload with padding-error detection.
module sti_deserializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  input  logic        cfg_fill,
  input  logic        si_data,
  input  logic        si_valid,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        po_pad_err,
  output logic        frame_err,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state;

  logic [1:0]  len_q;
  logic        msb_q;
  logic        low_q;
  logic        fill_q;

  logic [31:0] asm_q;
  logic [5:0]  cnt_q;

  logic [5:0]  frame_bits;
  logic [31:0] asm_base;
  logic [5:0]  cnt_base;
  logic [4:0]  bit_pos;
  logic [31:0] asm_next;
  logic [5:0]  cnt_next;
  logic        last_bit;
  logic [15:0] ext_data;
  logic        ext_pad;

  // A new frame always starts from a cleared register, whether entered from
  // IDLE or back-to-back out of OUT.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    frame_bits = {1'b0, len_q, 3'b000} + 6'd8;
    asm_base   = (state == RECV) ? asm_q : 32'h0000_0000;
    cnt_base   = (state == RECV) ? cnt_q : 6'd0;
    bit_pos    = msb_q ? 5'(frame_bits - 6'd1 - cnt_base) : 5'(cnt_base);
    asm_next   = asm_base;
    asm_next[bit_pos] = si_data;
    cnt_next   = cnt_base + 6'd1;
    last_bit   = (cnt_next == frame_bits);
  end

  // Payload extraction and padding check on the frame as it will look once
  // the current bit is stored.
  always_comb begin
    ext_data = asm_next[15:0];
    ext_pad  = 1'b0;
    unique case (len_q)
      2'd0: ext_data = low_q ? {asm_next[7:0], 8'h00} : {8'h00, asm_next[7:0]};
      2'd1: ext_data = asm_next[15:0];
      2'd2: begin
        if (fill_q) begin
          ext_data = asm_next[23:8];
          ext_pad  = |asm_next[7:0];
        end else begin
          ext_data = asm_next[15:0];
          ext_pad  = |asm_next[23:16];
        end
      end
      2'd3: begin
        if (fill_q) begin
          ext_data = asm_next[31:16];
          ext_pad  = |asm_next[15:0];
        end else begin
          ext_data = asm_next[15:0];
          ext_pad  = |asm_next[31:16];
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= 2'd0;
      msb_q      <= 1'b0;
      low_q      <= 1'b0;
      fill_q     <= 1'b0;
      asm_q      <= 32'h0000_0000;
      cnt_q      <= 6'd0;
      po_data    <= 16'h0000;
      po_valid   <= 1'b0;
      po_pad_err <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      po_valid   <= 1'b0;
      po_pad_err <= 1'b0;
      frame_err  <= 1'b0;

      if (cfg_load) begin
        // A config change always wins over serial data and kills any partial frame.
        len_q  <= cfg_length;
        msb_q  <= cfg_msb;
        low_q  <= cfg_low;
        fill_q <= cfg_fill;
        if (state == RECV) begin
          frame_err <= 1'b1;
        end
        asm_q <= 32'h0000_0000;
        cnt_q <= 6'd0;
        state <= IDLE;
        busy  <= 1'b0;
      end else if (si_valid) begin
        if (last_bit) begin
          asm_q      <= asm_next;
          cnt_q      <= 6'd0;
          state      <= OUT;
          busy       <= 1'b0;
          po_valid   <= 1'b1;
          po_data    <= ext_data;
          po_pad_err <= ext_pad;
          frame_cnt  <= frame_cnt + 8'd1;
        end else begin
          asm_q <= asm_next;
          cnt_q <= cnt_next;
          state <= RECV;
          busy  <= 1'b1;
        end
      end else begin
        if (state == RECV) begin
          frame_err <= 1'b1;
          asm_q     <= 32'h0000_0000;
        end
        cnt_q <= 6'd0;
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule
